// File: rtl/calc_key_entry.sv
// calc_key_entry: keypad sequencer assembling operands and operator for the ALU.
// Optional macro CALC_CHAIN_EN: an operator key in SHOW chains on calc_result.
module calc_key_entry #(
  parameter int OPERAND_W  = 4,
  parameter int OPCODE_W   = 3,
  parameter int MAX_DIGITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           key_code,
  input  logic                 key_valid,
  input  logic [7:0]           calc_result,
  output logic [OPERAND_W-1:0] operand1,
  output logic [OPERAND_W-1:0] operand2,
  output logic [OPCODE_W-1:0]  md_operator,
  output logic                 show_res,
  output logic                 err,
  output logic [2:0]           state_o
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP1  = 3'd1,
    OP2  = 3'd2,
    SHOW = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int WW = OPERAND_W + 5;
  localparam logic [WW-1:0] MAXV = WW'((2 ** OPERAND_W) - 1);
  localparam logic [OPCODE_W-1:0] MD_IDLE = '1;

  state_e                state_q, state_d;
  logic [OPERAND_W-1:0]  op1_q, op1_d;
  logic [OPERAND_W-1:0]  op2_q, op2_d;
  logic [OPCODE_W-1:0]   md_q, md_d;
  logic                  show_q, show_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  is_dig, is_op, is_eq, is_clr;
  logic                  is_un, is_dm, acc_bad, to_err;
  logic [OPCODE_W-1:0]   md_key;
  logic [OPERAND_W-1:0]  dig, acc_src;
  logic [WW-1:0]         acc;

  assign is_dig = key_valid && (key_code <= 5'd9);
  assign is_op  = key_valid && (key_code >= 5'h10) && (key_code <= 5'h16);
  assign is_eq  = key_valid && (key_code == 5'h1E);
  assign is_clr = key_valid && (key_code == 5'h1F);
  assign md_key = OPCODE_W'(key_code[2:0]);
  assign is_un  = (key_code[2:0] == 3'd5) || (key_code[2:0] == 3'd6);
  assign is_dm  = (md_q == OPCODE_W'(3)) || (md_q == OPCODE_W'(4));
  assign dig    = OPERAND_W'(key_code[3:0]);

  // Digits accumulate wide so an overflowing entry is caught, not wrapped.
  assign acc_src = (state_q == OP2) ? op2_q : op1_q;
  assign acc     = WW'(acc_src) * WW'(10) + WW'(key_code[3:0]);
  assign acc_bad = (acc > MAXV) || (cnt_q == CW'(MAX_DIGITS));

`ifdef CALC_CHAIN_EN
  logic cr_ok;
  assign cr_ok = calc_result <= 8'((2 ** OPERAND_W) - 1);
`else
  logic unused_calc;
  assign unused_calc = ^calc_result;
`endif

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    md_d    = md_q;
    show_d  = show_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    to_err  = 1'b0;
    if (is_clr) begin
      state_d = IDLE;
      op1_d   = '0;
      op2_d   = '0;
      md_d    = MD_IDLE;
      show_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_dig) begin
            op1_d   = dig;
            cnt_d   = CW'(1);
            state_d = OP1;
          end
        end
        OP1: begin
          if (is_dig) begin
            if (acc_bad) begin
              to_err = 1'b1;
            end else begin
              op1_d = acc[OPERAND_W-1:0];
              cnt_d = cnt_q + CW'(1);
            end
          end else if (is_op) begin
            md_d  = md_key;
            op2_d = '0;
            if (is_un) begin
              show_d  = 1'b1;
              state_d = SHOW;
            end else begin
              cnt_d   = '0;
              state_d = OP2;
            end
          end
        end
        OP2: begin
          if (is_dig) begin
            if (acc_bad) begin
              to_err = 1'b1;
            end else begin
              op2_d = acc[OPERAND_W-1:0];
              cnt_d = cnt_q + CW'(1);
            end
          end else if (is_op && cnt_q == '0) begin
            md_d = md_key;
            if (is_un) begin
              show_d  = 1'b1;
              state_d = SHOW;
            end
          end else if (is_eq && cnt_q != '0) begin
            if (is_dm && op2_q == '0) begin
              to_err = 1'b1;
            end else begin
              show_d  = 1'b1;
              state_d = SHOW;
            end
          end
        end
        SHOW: begin
          if (is_dig) begin
            show_d  = 1'b0;
            md_d    = MD_IDLE;
            op1_d   = dig;
            op2_d   = '0;
            cnt_d   = CW'(1);
            state_d = OP1;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op) begin
            if (!cr_ok) begin
              to_err = 1'b1;
            end else begin
              op1_d = calc_result[OPERAND_W-1:0];
              md_d  = md_key;
              op2_d = '0;
              if (!is_un) begin
                cnt_d   = '0;
                show_d  = 1'b0;
                state_d = OP2;
              end
            end
          end
`endif
        end
        ERR: begin
        end
        default: state_d = IDLE;
      endcase
      if (to_err) begin
        state_d = ERR;
        err_d   = 1'b1;
        show_d  = 1'b0;
        md_d    = MD_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      md_q    <= MD_IDLE;
      show_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      md_q    <= md_d;
      show_q  <= show_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign operand1    = op1_q;
  assign operand2    = op2_q;
  assign md_operator = md_q;
  assign show_res    = show_q;
  assign err         = err_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_calc_key_entry.sv
// tb_calc_key_entry: directed scenarios plus random key streams
// compared against a behavioural calculator-entry model.
module tb_calc_key_entry;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] key_code = '0;
  logic       key_valid = 1'b0;
  logic [7:0] calc_result = '0;
  logic [3:0] operand1, operand2;
  logic [2:0] md_operator, state_o;
  logic       show_res, err;

  calc_key_entry dut (
    .clk(clk), .rst_n(rst_n),
    .key_code(key_code), .key_valid(key_valid),
    .calc_result(calc_result),
    .operand1(operand1), .operand2(operand2),
    .md_operator(md_operator), .show_res(show_res),
    .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int m_st, m_op1, m_op2, m_md, m_show, m_err, m_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic m_reset();
    m_st = 0; m_op1 = 0; m_op2 = 0; m_md = 7;
    m_show = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic m_fault();
    m_st = 4; m_err = 1; m_show = 0; m_md = 7;
  endtask

  // Behavioural entry rules: one accepted key at a time.
  task automatic m_key(input int k, input int cr);
    int v, op;
    if (k == 31) begin
      m_reset();
    end else if (k <= 9) begin
      if (m_st == 0) begin
        m_op1 = k; m_cnt = 1; m_st = 1;
      end else if (m_st == 1 || m_st == 2) begin
        v = (m_st == 1 ? m_op1 : m_op2) * 10 + k;
        if (v > 15 || m_cnt == 2) m_fault();
        else begin
          if (m_st == 1) m_op1 = v; else m_op2 = v;
          m_cnt++;
        end
      end else if (m_st == 3) begin
        m_show = 0; m_md = 7; m_op1 = k; m_op2 = 0;
        m_cnt = 1; m_st = 1;
      end
    end else if (k >= 16 && k <= 22) begin
      op = k - 16;
      if (m_st == 1) begin
        m_md = op; m_op2 = 0;
        if (op >= 5) begin m_st = 3; m_show = 1; end
        else begin m_st = 2; m_cnt = 0; end
      end else if (m_st == 2 && m_cnt == 0) begin
        m_md = op;
        if (op >= 5) begin m_st = 3; m_show = 1; end
      end else if (m_st == 3) begin
`ifdef CALC_CHAIN_EN
        if (cr > 15) m_fault();
        else begin
          m_op1 = cr; m_md = op; m_op2 = 0;
          if (op < 5) begin m_cnt = 0; m_show = 0; m_st = 2; end
        end
`else
        v = cr;
`endif
      end
    end else if (k == 30) begin
      if (m_st == 2 && m_cnt != 0) begin
        if ((m_md == 3 || m_md == 4) && m_op2 == 0) m_fault();
        else begin m_st = 3; m_show = 1; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, int'(state_o), m_st);
    chk({tag, ".show"}, int'(show_res), m_show);
    chk({tag, ".err"}, int'(err), m_err);
    chk({tag, ".md"}, int'(md_operator), m_md);
    if (m_st != 4) begin
      chk({tag, ".op1"}, int'(operand1), m_op1);
      chk({tag, ".op2"}, int'(operand2), m_op2);
    end
  endtask

  task automatic press(input int k, input bit v, input string tag);
    @(negedge clk);
    key_code = 5'(k);
    key_valid = v;
    if (v) m_key(k, int'(calc_result));
    @(negedge clk);
    key_valid = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int r, c, k;
    #12;
    m_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    press(1, 1, "t1a"); press(2, 1, "t1b"); press(16, 1, "t1c");
    press(3, 1, "t1d"); press(30, 1, "t1e");
    chk("t1.show", int'(show_res), 1);

    press(31, 1, "clr");
    press(9, 1, "t2a"); press(21, 1, "t2b");
    chk("t2.md", int'(md_operator), 5);

    press(31, 1, "clr");
    press(1, 1, "t3a"); press(6, 1, "t3b");
    chk("t3.err", int'(err), 1);
    press(4, 1, "t3c"); press(31, 1, "t3d");

    press(8, 1, "t4a"); press(19, 1, "t4b"); press(0, 1, "t4c");
    press(30, 1, "t4d");
    chk("t4.err", int'(err), 1);
    press(31, 1, "clr");
    press(7, 1, "t4e"); press(20, 1, "t4f"); press(30, 1, "t4g");
    chk("t4.state", int'(state_o), 2);

    press(31, 1, "clr");
    press(5, 1, "t5a"); press(16, 1, "t5b");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_all("t5.async");
    @(negedge clk);
    rst_n = 1'b1;

    press(2, 1, "t6a"); press(18, 1, "t6b"); press(3, 1, "t6c");
    press(30, 1, "t6d");
    calc_result = 8'd6;
    press(16, 1, "t6e"); press(4, 1, "t6f"); press(30, 1, "t6g");
    press(31, 1, "clr");

    for (int i = 0; i < 400; i++) begin
      calc_result = 8'($urandom_range(0, 31));
      r = $urandom_range(0, 99);
      if (r < 45) press($urandom_range(0, 9), 1, "rnd.dig");
      else if (r < 65) press($urandom_range(16, 22), 1, "rnd.op");
      else if (r < 75) press(30, 1, "rnd.eq");
      else if (r < 79) press(31, 1, "rnd.clr");
      else if (r < 87) begin
        c = $urandom_range(0, 12);
        k = (c < 6) ? 10 + c : 23 + (c - 6);
        press(k, 1, "rnd.ign");
      end else press($urandom_range(0, 31), 0, "rnd.idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
